// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bus of the 4-way round-robin mux arbiter.
// The requester side drives req/d; the arbiter returns grant/sel/valid/y.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       valid;
  logic       y;

  modport master (output req, d, input grant, sel, valid, y);
  modport slave  (input req, d, output grant, sel, valid, y);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 single-bit mux among four requesters.
// A hold limit forces rotation when another requester is waiting.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  mux4_rr_arbiter_if.slave   bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [0:0]       r_state;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_grant;
  logic [1:0]       r_sel;
  logic             r_valid;

  logic [3:0] w_others;
  logic       w_release;
  logic [1:0] w_arb_ptr;
  logic [3:0] w_arb_req;
  logic [1:0] w_win;
  logic       w_found;

  assign w_others  = bus.req & ~r_grant;
  assign w_release = (r_state == S_GRANT) &&
                     (!bus.req[r_sel] || ((r_cnt == HOLD_LAST) && (w_others != 4'b0)));
  // On release the search already starts one past the outgoing owner.
  assign w_arb_ptr = w_release ? (r_sel + 2'd1) : r_ptr;
  assign w_arb_req = (r_state == S_IDLE) ? bus.req : w_others;

  always_comb begin
    logic [1:0] idx;
    w_win   = 2'd0;
    w_found = 1'b0;
    idx     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = w_arb_ptr + 2'(i);
      if (!w_found && w_arb_req[idx]) begin
        w_win   = idx;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      r_cnt   <= '0;
      r_grant <= 4'b0000;
      r_sel   <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= 4'b0001 << w_win;
            r_sel   <= w_win;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_GRANT;
          end
        end
        default: begin
          if (w_release) begin
            r_ptr <= r_sel + 2'd1;
            if (w_found) begin
              r_grant <= 4'b0001 << w_win;
              r_sel   <= w_win;
              r_cnt   <= '0;
            end else begin
              // sel deliberately keeps the last owner while idle
              r_grant <= 4'b0000;
              r_valid <= 1'b0;
              r_state <= S_IDLE;
            end
          end else if (r_cnt != HOLD_LAST) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.grant = r_grant;
  assign bus.sel   = r_sel;
  assign bus.valid = r_valid;
  assign bus.y     = r_valid & bus.d[r_sel];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: two instances (MAX_HOLD 2 and 8) share stimulus
// and are compared against an owner/ptr reference model each cycle.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] d;

  int n_tot = 0;
  int n_bad = 0;

  localparam int MH [2] = '{2, 8};

  mux4_rr_arbiter_if ifa ();
  mux4_rr_arbiter_if ifb ();

  assign ifa.req = req;
  assign ifa.d   = d;
  assign ifb.req = req;
  assign ifb.d   = d;

  mux4_rr_arbiter #(.MAX_HOLD(2), .CNT_W(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  mux4_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: owner index (-1 idle), priority pointer, cycles owned, last sel
  int m_own [2];
  int m_ptr [2];
  int m_held[2];
  int m_sel [2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++)
      if (r[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_own[j] = -1; m_ptr[j] = 0; m_held[j] = 0; m_sel[j] = 0;
    end
  endtask

  task automatic model_step(input logic [3:0] r);
    for (int j = 0; j < 2; j++) begin
      if (m_own[j] < 0) begin
        if (r != 4'b0) begin
          m_own[j] = pick(r, m_ptr[j]); m_sel[j] = m_own[j]; m_held[j] = 1;
        end
      end else begin
        logic [3:0] oth;
        oth = r & ~(4'b0001 << m_own[j]);
        if (!r[m_own[j]] || (m_held[j] >= MH[j] && oth != 4'b0)) begin
          m_ptr[j] = (m_own[j] + 1) % 4;
          if (oth != 4'b0) begin
            m_own[j] = pick(oth, m_ptr[j]); m_sel[j] = m_own[j]; m_held[j] = 1;
          end else begin
            m_own[j] = -1;
          end
        end else begin
          m_held[j]++;
        end
      end
    end
  endtask

  function automatic logic [3:0] exp_grant(input int j);
    return (m_own[j] < 0) ? 4'b0000 : (4'b0001 << m_own[j]);
  endfunction

  function automatic logic exp_y(input int j);
    return (m_own[j] >= 0) && d[m_sel[j]];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_grant_a"}, {4'b0, ifa.grant}, {4'b0, exp_grant(0)});
    chk({tag, "_sel_a"},   {6'b0, ifa.sel},   8'(m_sel[0]));
    chk({tag, "_valid_a"}, {7'b0, ifa.valid}, {7'b0, m_own[0] >= 0});
    chk({tag, "_y_a"},     {7'b0, ifa.y},     {7'b0, exp_y(0)});
    chk({tag, "_grant_b"}, {4'b0, ifb.grant}, {4'b0, exp_grant(1)});
    chk({tag, "_sel_b"},   {6'b0, ifb.sel},   8'(m_sel[1]));
    chk({tag, "_valid_b"}, {7'b0, ifb.valid}, {7'b0, m_own[1] >= 0});
    chk({tag, "_y_b"},     {7'b0, ifb.y},     {7'b0, exp_y(1)});
  endtask

  // Called at a negedge: drive, check combinational y, advance one edge, check.
  task automatic step(input string tag, input logic [3:0] r, input logic [3:0] dd);
    req = r;
    d   = dd;
    #1;
    chk({tag, "_ycomb_a"}, {7'b0, ifa.y}, {7'b0, exp_y(0)});
    chk({tag, "_ycomb_b"}, {7'b0, ifb.y}, {7'b0, exp_y(1)});
    model_step(r);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [3:0] rr_exp [9];
  int         cnt;

  initial begin
    rst = 1'b1; req = 4'b0; d = 4'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("por");
    rst = 1'b0;
    step("idle0", 4'b0000, 4'b0000);
    step("idle1", 4'b0000, 4'b1111);

    // single request, data mirroring, then drop
    step("single", 4'b0100, 4'b0000);
    chk("single_grant", {4'b0, ifb.grant}, 8'h04);
    chk("single_sel",   {6'b0, ifb.sel},   8'h02);
    step("mirror1", 4'b0100, 4'b0100);
    step("mirror0", 4'b0100, 4'b1011);
    step("mirror2", 4'b0100, 4'b0100);
    step("drop", 4'b0000, 4'b0100);
    chk("drop_valid", {7'b0, ifb.valid}, 8'h00);

    // async reset between edges while owner 2 holds the grant
    step("pre_rst", 4'b0100, 4'b0100);
    step("pre_rst2", 4'b0100, 4'b0100);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_grant", {4'b0, ifa.grant}, 8'h00);
    chk("midrst_y",     {7'b0, ifa.y},     8'h00);
    check_all("midrst");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 4'b0000, 4'b0100);
    chk("post_rst_valid", {7'b0, ifa.valid}, 8'h00);

    // all four requesting on the MAX_HOLD=2 instance
    rr_exp = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
               4'b0100, 4'b1000, 4'b1000, 4'b0001};
    for (int i = 0; i < 9; i++) begin
      step("rr", 4'b1111, 4'(i));
      chk("rr_order", {4'b0, ifa.grant}, {4'b0, rr_exp[i]});
    end

    // back-to-back handoff from owner 1 to owner 3
    do_reset();
    step("b2b0", 4'b0010, 4'b0000);
    step("b2b1", 4'b0010, 4'b0000);
    step("b2b2", 4'b1000, 4'b1000);
    chk("b2b_grant", {4'b0, ifb.grant}, 8'h08);
    chk("b2b_valid", {7'b0, ifb.valid}, 8'h01);
    step("b2b3", 4'b0000, 4'b0000);

    // starvation limit on the MAX_HOLD=8 instance
    do_reset();
    step("starve0", 4'b0001, 4'b0000);
    cnt = 1;
    for (int i = 0; i < 20 && ifb.grant == 4'b0001; i++) begin
      step("starve", 4'b0011, 4'b0001);
      if (ifb.grant == 4'b0001) cnt++;
    end
    chk("starve_len",   8'(cnt),           8'd8);
    chk("starve_grant", {4'b0, ifb.grant}, 8'h02);
    step("starve_back", 4'b0001, 4'b0000);
    chk("starve_back_grant", {4'b0, ifb.grant}, 8'h01);

    // isolation: only owner 3 data reaches y
    do_reset();
    step("iso0", 4'b1000, 4'b0111);
    chk("iso_y0", {7'b0, ifb.y}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step("iso", 4'b1000, {1'b0, 3'($urandom)});
      chk("iso_low", {7'b0, ifb.y}, 8'h00);
    end
    step("iso1", 4'b1000, 4'b1000);
    chk("iso_y1", {7'b0, ifb.y}, 8'h01);

    // randomized traffic with occasional async reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        #2;
        do_reset();
      end
      step("rnd", 4'($urandom), 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
